// File: rtl/i2s_serdes.sv
// i2s_serdes: I2S master transceiver.
// Sequences the codec reset, generates MCLK/SCLK/LRCLK, serializes two 24-bit
// channel words per 64-bit frame onto SDIN and deserializes SDOUT into words
// handed back to the core with per-channel strobes.
module i2s_serdes #(
    parameter int RST_CYCLES  = 1024,
    parameter int INIT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mclk_rate,
    input  logic [2:0]  sclk_rate,
    output logic        init_done,
    output logic        codec_rstn,
    output logic        codec_mclk,
    output logic        codec_sclk,
    output logic        codec_lrclk,
    output logic        codec_sdin,
    input  logic        codec_sdout,
    input  logic [23:0] aud_din0,
    input  logic [23:0] aud_din1,
    output logic [1:0]  aud_din_ack,
    output logic [23:0] aud_dout,
    output logic [1:0]  aud_dout_vld
);

    localparam int DATA_W     = 24;
    localparam int MAX_CYCLES = (RST_CYCLES > INIT_CYCLES) ? RST_CYCLES : INIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   seq_cnt;

    logic [2:0]         mclk_lat;
    logic [2:0]         sclk_lat;
    logic [3:0]         rate_sum;
    logic [14:0]        prescale;
    logic [14:0]        mclk_mask;
    logic [14:0]        half_m1;
    logic [14:0]        half_cnt;

    logic               run;
    logic               sclk_tick;
    logic               rise;
    logic               fall;
    logic               wrap;
    logic               data_slot;

    logic [5:0]         bit_cnt;
    logic [5:0]         bit_next;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-1:0]  rx_shift;
    logic               rx_done;

    assign run       = (state == ST_RUN);
    assign rate_sum  = {1'b0, mclk_lat} + {1'b0, sclk_lat};
    assign mclk_mask = (15'd1 << mclk_lat) - 15'd1;
    assign half_m1   = (15'd1 << rate_sum) - 15'd1;
    assign sclk_tick = run && (half_cnt == half_m1);
    assign rise      = sclk_tick && !codec_sclk;
    assign fall      = sclk_tick && codec_sclk;
    assign bit_next  = bit_cnt + 6'd1;
    assign wrap      = fall && (bit_cnt == 6'd63);
    // Data bit periods of a slot are b[4:0] = 1..24.
    assign data_slot = (bit_cnt[4:0] >= 5'd1) && (bit_cnt[4:0] <= 5'd24);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next-state logic: RST -> WAIT -> RUN, RUN is held until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_RST: begin
                if (seq_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (seq_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RST;
            end
        endcase
    end

    // Sequencer outputs decoded from the state alone.
    always_comb begin
        codec_rstn = 1'b0;
        init_done  = 1'b0;
        case (state)
            ST_WAIT: begin
                codec_rstn = 1'b1;
            end
            ST_RUN: begin
                codec_rstn = 1'b1;
                init_done  = 1'b1;
            end
            default: begin
                codec_rstn = 1'b0;
                init_done  = 1'b0;
            end
        endcase
    end

    // Dwell counter for RST and WAIT; cleared on every state change, idle in RUN.
    always_ff @(posedge clk) begin
        if (rst || (state_next != state)) begin
            seq_cnt <= '0;
        end else if (!run) begin
            seq_cnt <= seq_cnt + CNT_W'(1);
        end
    end

    // Rate latch: tracks the inputs while in reset, afterwards only at frame wrap.
    always_ff @(posedge clk) begin
        if (rst || wrap) begin
            mclk_lat <= mclk_rate;
            sclk_lat <= sclk_rate;
        end
    end

    // MCLK prescaler: free-running in every sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale   <= '0;
            codec_mclk <= 1'b0;
        end else begin
            prescale <= prescale + 15'd1;
            if ((prescale & mclk_mask) == mclk_mask) begin
                codec_mclk <= ~codec_mclk;
            end
        end
    end

    // SCLK half-period timer; idle low until RUN so the first toggle rises.
    // It restarts on each toggle, so a rate taken at frame wrap starts a full phase.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            half_cnt   <= '0;
            codec_sclk <= 1'b0;
        end else if (sclk_tick) begin
            half_cnt   <= '0;
            codec_sclk <= ~codec_sclk;
        end else begin
            half_cnt <= half_cnt + 15'd1;
        end
    end

    // Bit counter, LRCLK, SDIN and transmit acks all advance on SCLK falling edges.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            bit_cnt     <= 6'd63;
            codec_lrclk <= 1'b0;
            codec_sdin  <= 1'b0;
            aud_din_ack <= '0;
        end else begin
            aud_din_ack <= '0;
            if (fall) begin
                bit_cnt     <= bit_next;
                codec_lrclk <= bit_next[5];
                if (bit_next[4:0] == 5'd0) begin
                    codec_sdin               <= 1'b0;
                    aud_din_ack[bit_next[5]] <= 1'b1;
                end else if (bit_next[4:0] <= 5'd24) begin
                    codec_sdin <= tx_shift[DATA_W-1];
                end else begin
                    codec_sdin <= 1'b0;
                end
            end
        end
    end

    // TX shift register: load at slot start, then one bit out per falling edge.
    always_ff @(posedge clk) begin
        if (fall) begin
            if (bit_next[4:0] == 5'd0) begin
                tx_shift <= bit_next[5] ? aud_din1 : aud_din0;
            end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    // RX shift register: sample SDOUT on rising edges of the 24 data bit periods.
    always_ff @(posedge clk) begin
        if (rise && data_slot) begin
            rx_shift <= {rx_shift[DATA_W-2:0], codec_sdout};
        end
    end

    // Word completion: publish the received word one clk after its last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done      <= 1'b0;
            aud_dout_vld <= '0;
            aud_dout     <= '0;
        end else begin
            rx_done      <= rise && (bit_cnt[4:0] == 5'd24);
            aud_dout_vld <= '0;
            if (rx_done) begin
                aud_dout              <= rx_shift;
                aud_dout_vld[bit_cnt[5]] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_serdes.sv
// tb_i2s_serdes: randomized bench for i2s_serdes with a cycle-level reference
// model built from the frame/slot rules (event times and bit positions).
module tb_i2s_serdes;

    localparam int RSTC  = 16;
    localparam int INITC = 8;
    localparam int T0    = RSTC + INITC;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mclk_rate;
    logic [2:0]  sclk_rate;
    logic        init_done;
    logic        codec_rstn;
    logic        codec_mclk;
    logic        codec_sclk;
    logic        codec_lrclk;
    logic        codec_sdin;
    logic        codec_sdout;
    logic [23:0] aud_din0;
    logic [23:0] aud_din1;
    logic [1:0]  aud_din_ack;
    logic [23:0] aud_dout;
    logic [1:0]  aud_dout_vld;

    always #5 clk = ~clk;

    i2s_serdes #(
        .RST_CYCLES  (RSTC),
        .INIT_CYCLES (INITC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mclk_rate    (mclk_rate),
        .sclk_rate    (sclk_rate),
        .init_done    (init_done),
        .codec_rstn   (codec_rstn),
        .codec_mclk   (codec_mclk),
        .codec_sclk   (codec_sclk),
        .codec_lrclk  (codec_lrclk),
        .codec_sdin   (codec_sdin),
        .codec_sdout  (codec_sdout),
        .aud_din0     (aud_din0),
        .aud_din1     (aud_din1),
        .aud_din_ack  (aud_din_ack),
        .aud_dout     (aud_dout),
        .aud_dout_vld (aud_dout_vld)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    int          c;          // cycles since the last reset edge
    int          m_rel;      // mclk_rate taken at reset release
    int          m_lat;
    int          s_lat;
    int          next_tog;   // model cycle of the next SCLK toggle
    int          bcnt;       // frame bit position
    logic        e_sclk, e_lr, e_sdin;
    logic [1:0]  e_ack, e_vld;
    logic [23:0] e_dout, txw, rxw;
    logic        vld_due;
    int          vld_ch;

    // Stimulus present during the cycle before the current edge
    logic        p_rst, p_sdout;
    logic [2:0]  p_m, p_s;
    logic [23:0] p_d0, p_d1;

    // Stimulus modes
    logic        rnd_data, loopback, lb_check;
    logic [23:0] lb0, lb1;

    // Observation trackers for the clock-rate measurements
    logic        last_rstn, last_init, last_lr, last_sclk;
    int          rstn_rise_c, init_rise_c, lr_rise_c, lr_fall_c, lr_period, lr_high;
    int          sclk_tog_c, sclk_phase;

    task automatic step_model();
        int p;
        int ch;
        e_ack = 2'b00;
        e_vld = 2'b00;
        if (p_rst) begin
            c        = 0;
            m_rel    = p_m;
            m_lat    = p_m;
            s_lat    = p_s;
            next_tog = T0 + (1 << (p_m + p_s));
            bcnt     = 63;
            e_sclk   = 1'b0;
            e_lr     = 1'b0;
            e_sdin   = 1'b0;
            e_dout   = 24'h0;
            vld_due  = 1'b0;
        end else begin
            c++;
            if (vld_due) begin
                e_dout        = rxw;
                e_vld[vld_ch] = 1'b1;
                vld_due       = 1'b0;
            end
            if (c == next_tog) begin
                e_sclk = ~e_sclk;
                if (e_sclk) begin
                    p = bcnt % 32;
                    if (p >= 1 && p <= 24) rxw[24 - p] = p_sdout;
                    if (p == 24) begin
                        vld_due = 1'b1;
                        vld_ch  = bcnt / 32;
                    end
                end else begin
                    bcnt = (bcnt + 1) % 64;
                    e_lr = (bcnt >= 32);
                    p    = bcnt % 32;
                    if (p == 0) begin
                        ch        = bcnt / 32;
                        txw       = (ch == 1) ? p_d1 : p_d0;
                        e_ack[ch] = 1'b1;
                        e_sdin    = 1'b0;
                        if (bcnt == 0) begin
                            m_lat = p_m;
                            s_lat = p_s;
                        end
                    end else if (p <= 24) begin
                        e_sdin = txw[24 - p];
                    end else begin
                        e_sdin = 1'b0;
                    end
                end
                next_tog = c + (1 << (m_lat + s_lat));
            end
        end
    endtask

    task automatic tick();
        p_rst   = rst;
        p_m     = mclk_rate;
        p_s     = sclk_rate;
        p_sdout = codec_sdout;
        p_d0    = aud_din0;
        p_d1    = aud_din1;
        @(posedge clk);
        #1;
        cyc++;
        step_model();
        check_eq("mclk",      32'(codec_mclk),   32'((c >> m_rel) & 1));
        check_eq("rstn",      32'(codec_rstn),   32'(c >= RSTC));
        check_eq("init_done", 32'(init_done),    32'(c >= T0));
        check_eq("sclk",      32'(codec_sclk),   32'(e_sclk));
        check_eq("lrclk",     32'(codec_lrclk),  32'(e_lr));
        check_eq("sdin",      32'(codec_sdin),   32'(e_sdin));
        check_eq("din_ack",   32'(aud_din_ack),  32'(e_ack));
        check_eq("dout_vld",  32'(aud_dout_vld), 32'(e_vld));
        check_eq("dout",      32'(aud_dout),     32'(e_dout));
        if (lb_check && (e_vld != 2'b00)) begin
            check_eq("loop_word", 32'(aud_dout), 32'(e_vld[1] ? lb1 : lb0));
        end
        if (codec_rstn && !last_rstn) rstn_rise_c = c;
        if (init_done && !last_init) init_rise_c = c;
        if (codec_lrclk && !last_lr) lr_rise_c = c;
        if (!codec_lrclk && last_lr) begin
            lr_high = c - lr_rise_c;
            if (lr_fall_c >= 0) lr_period = c - lr_fall_c;
            lr_fall_c = c;
        end
        if (codec_sclk != last_sclk) begin
            sclk_phase = c - sclk_tog_c;
            sclk_tog_c = c;
        end
        last_rstn = codec_rstn;
        last_init = init_done;
        last_lr   = codec_lrclk;
        last_sclk = codec_sclk;
        if (rnd_data) begin
            aud_din0 = 24'($urandom());
            aud_din1 = 24'($urandom());
        end
        if (loopback) codec_sdout = codec_sdin;
        else          codec_sdout = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_b(input int target);
        int guard;
        guard = 0;
        while ((bcnt != target) && (guard < 20000)) begin
            tick();
            guard++;
        end
        check_eq("wait_b", 32'(bcnt == target), 32'd1);
    endtask

    task automatic restart(input logic [2:0] m, input logic [2:0] s);
        rst       = 1'b1;
        mclk_rate = m;
        sclk_rate = s;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int h;
        rst = 1'b1; mclk_rate = 3'd0; sclk_rate = 3'd0; codec_sdout = 1'b0;
        aud_din0 = 24'h0; aud_din1 = 24'h0;
        rnd_data = 1'b0; loopback = 1'b0; lb_check = 1'b0; lb0 = 24'h0; lb1 = 24'h0;
        txw = 24'h0; rxw = 24'h0;
        last_rstn = 1'b0; last_init = 1'b0; last_lr = 1'b0; last_sclk = 1'b0;
        rstn_rise_c = -1; init_rise_c = -1; lr_rise_c = -1; lr_fall_c = -1;
        lr_period = -1; lr_high = -1; sclk_tog_c = 0; sclk_phase = -1;

        // Reset sequence and clock rates with random data: MCLK 8, SCLK 16 clk
        rnd_data = 1'b1;
        restart(3'd2, 3'd1);
        repeat (T0 + 2 * 1024 + 60) tick();
        check_eq("rstn_rise_cycle", 32'(rstn_rise_c), 32'd16);
        check_eq("init_rise_cycle", 32'(init_rise_c), 32'd24);
        check_eq("lrclk_period",    32'(lr_period),   32'd1024);
        check_eq("lrclk_high",      32'(lr_high),     32'd512);

        // Loopback with fixed words, H=2
        rnd_data = 1'b0; loopback = 1'b1; lb_check = 1'b1;
        lb0 = 24'hABCDEF; lb1 = 24'h123456;
        aud_din0 = lb0; aud_din1 = lb1;
        restart(3'd0, 3'd1);
        repeat (T0 + 3 * 256 + 20) tick();

        // Bit alignment at minimum setting H=1
        lb0 = 24'h800001; lb1 = 24'h5A5A5A;
        aud_din0 = lb0; aud_din1 = lb1;
        restart(3'd0, 3'd0);
        repeat (T0 + 3 * 128 + 10) tick();

        // Mid-frame SCLK rate change 0 -> 2 at b=10
        loopback = 1'b0; lb_check = 1'b0; rnd_data = 1'b1;
        restart(3'd0, 3'd0);
        wait_b(10);
        sclk_rate = 3'd2;
        repeat (3 * 512 + 200) tick();
        check_eq("sclk_phase_after", 32'(sclk_phase), 32'd4);

        // Reset mid-frame at b=40 with random rates
        restart(3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)));
        wait_b(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        h = 1 << (m_lat + s_lat);
        repeat (T0 + 2 * 128 * h + 20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_serdes.md
# i2s_serdes

I2S master transceiver for the CBI980 audio core. It generates the codec reset and clock set (MCLK, SCLK, LRCLK) and serializes two 24-bit channel words per frame onto SDIN. It deserializes SDOUT into 24-bit words and exchanges them with the core's FIFOs through per-channel valid/ack strobes. Channel 0 is the left channel (LRCLK low) and channel 1 is the right channel (LRCLK high).

## Interface
- RST_CYCLES, default 1024: clk cycles `codec_rstn` stays low after reset.
- INIT_CYCLES, default 1024: clk cycles from `codec_rstn` release until `init_done`.
- clk  in  1  core clock. Single clock domain.
- rst  in  1  reset, synchronous, active-high.
- mclk_rate  in  3  MCLK half-period is 2^mclk_rate clk cycles.
- sclk_rate  in  3  SCLK half-period is 2^(mclk_rate+sclk_rate) clk cycles.
- init_done  out  1  codec reset sequence is complete and frames are running.
- codec_rstn  out  1  codec reset, active-low.
- codec_mclk, codec_sclk, codec_lrclk  out  1 each  codec clocks.
- codec_sdin  out  1  serial data to the codec DAC.
- codec_sdout  in  1  serial data from the codec ADC.
- aud_din0, aud_din1  in  24 each  transmit words for channel 0 and channel 1.
- aud_din_ack  out  2  one-clk pulse per channel when its `aud_din` word is consumed.
- aud_dout  out  24  last received word.
- aud_dout_vld  out  2  one-clk pulse on the bit of the channel `aud_dout` belongs to.

## Operation
- **Reset values.** All outputs are 0 during and directly after reset: `codec_rstn`, `init_done`, every clock pin, `codec_sdin`, `aud_dout`, `aud_dout_vld`, `aud_din_ack`.
- **Sequencer.** States RST → WAIT → RUN.
  - RST: `codec_rstn`=0 for RST_CYCLES clk cycles, then go to WAIT.
  - WAIT: `codec_rstn`=1 for INIT_CYCLES clk cycles, then go to RUN.
  - RUN: `init_done`=1 and stays 1 until `rst`.
- **MCLK.** A free-running 15-bit prescaler toggles `codec_mclk` every 2^mclk_rate clk cycles. MCLK runs in all states, including RST.
- **SCLK, LRCLK, SDIN.** Run only in RUN; before RUN they are held at 0.
- **SCLK edge events.** SCLK toggles every H = 2^(mclk_rate+sclk_rate) clk cycles. The first toggle after entering RUN is a rising edge (R). A falling edge is F.
- **Frame.** 64 SCLK periods. A 6-bit bit counter b increments on every F and wraps from 63 to 0.
- **LRCLK.** `codec_lrclk` = b[5], updated on F. It therefore changes one SCLK period before the MSB, per standard I2S. Active channel ch = b[5].
- **Transmit.**
  - On the F where b[4:0] becomes 0: load `aud_din{ch}` into the TX shift register and pulse `aud_din_ack[ch]` in that same clk cycle.
  - On F with b[4:0] = 1..24: drive the shift bits MSB first on `codec_sdin`.
  - On F with b[4:0] = 25..31 and 0: drive `codec_sdin` = 0.
- **Receive.** On R with b[4:0] = 1..24, shift `codec_sdout` into the RX register, MSB first. One clk after the R with b[4:0] = 24: update `aud_dout` and pulse `aud_dout_vld[ch]`. `aud_dout` holds its value until the next update.
- **Rate latching.** `mclk_rate` and `sclk_rate` are sampled at reset release and again at every wrap of b from 63 to 0. A mid-frame rate change takes effect at the next frame start and never produces a short SCLK pulse. The MCLK prescaler uses the latched `mclk_rate` with the same rule.
- **No flow control.** An ack is issued whether or not the source has fresh data. The source supplies the held word and flags underflow itself.

## Timing
- Clock periods in clk cycles: MCLK = 2^(mclk_rate+1); SCLK = 2H; frame = 128·H.
- First ack after RUN: `aud_din_ack[0]` pulses at the first F of the first frame. Because the counter advances to 0 from its reset value of 63, the first frame begins on channel 0.
- `aud_din_ack[1]` pulses 32 SCLK periods after `aud_din_ack[0]`, at the F where b becomes 32.
- RX latency: `aud_dout_vld` pulses 1 clk after the 24th sampling edge, and before the next ack for the same channel.
- Each pulse (`aud_din_ack`, `aud_dout_vld`) is exactly one clk wide, at most one per channel per frame. The two channels never pulse in the same cycle.
- `rst` asserted mid-frame: next cycle every output returns to its reset value and the sequencer restarts in RST. The partial word is discarded and no pulse is emitted.
- Minimum setting H=1 (both rates 0): SCLK period is 2 clk. All events still occur in distinct cycles; TX load and F coincide.

## Test plan
- **Reset sequence:** deassert `rst` with RST_CYCLES=16, INIT_CYCLES=8 → `codec_rstn` rises at cycle 16, `init_done` rises at cycle 24, MCLK toggles throughout.
- **Clock rates:** mclk_rate=2, sclk_rate=1 → MCLK period 8 clk, SCLK period 16 clk, LRCLK period 1024 clk with 50% duty.
- **Loopback:** `codec_sdout` tied to `codec_sdin`, aud_din0=0xABCDEF, aud_din1=0x123456 → `aud_dout_vld[0]` with `aud_dout`=0xABCDEF and `aud_dout_vld[1]` with `aud_dout`=0x123456, every frame. Exactly one ack and one vld per channel per frame.
- **Bit alignment:** aud_din0=0x800001 → SDIN high on the first and 24th SCLK periods after LRCLK falls, low on all other periods of that channel slot.
- **Rate change mid-frame:** change sclk_rate 0→2 at b=10 → SCLK period unchanged until b wraps to 0, then 4× longer. No SCLK high or low phase is shorter than H.
- **Reset mid-frame:** assert `rst` for 1 cycle at b=40 → all outputs 0 next cycle, no ack or vld pulses, full RST/WAIT sequence repeats.
